// File: rtl/result_streamer.sv
// Streams a captured packed result matrix out one element per valid/ready transfer.
// Element 0 sits in the most significant field of mat_in.
module result_streamer #(
    parameter int ELEM_W = 10,
    parameter int N_ELEM = 16
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [ELEM_W*N_ELEM-1:0] mat_in,
    input  logic                     start,
    input  logic                     elem_ready,
    output logic                     elem_valid,
    output logic [ELEM_W-1:0]        elem_data,
    output logic [3:0]               elem_idx,
    output logic                     elem_last,
    output logic                     busy,
    output logic                     done
);

    localparam int         MAT_W    = ELEM_W * N_ELEM;
    localparam logic [3:0] LAST_IDX = 4'(N_ELEM - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SEND = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t              state_r;
    logic [MAT_W-1:0]    snap_r;
    logic [3:0]          idx_r;
    logic                valid_r;
    logic [ELEM_W-1:0]   data_r;
    logic                last_r;
    logic                busy_r;
    logic                done_r;

    logic [3:0]          idx_inc_s;
    logic [ELEM_W-1:0]   next_data_s;

    // Raw field extraction; element idx counted from the top of the packed vector.
    function automatic logic [ELEM_W-1:0] elem_at(input logic [MAT_W-1:0] mat,
                                                  input logic [3:0]       idx);
        int pos;
        pos     = (N_ELEM - 1 - int'(idx)) * ELEM_W;
        elem_at = ELEM_W'(mat >> pos);
    endfunction

    // Next index and its element, looked up from the snapshot only.
    always_comb begin
        idx_inc_s   = idx_r + 4'd1;
        next_data_s = elem_at(snap_r, idx_inc_s);
    end

    // Control FSM with all outputs registered alongside the state.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= IDLE;
            snap_r  <= '0;
            idx_r   <= 4'd0;
            valid_r <= 1'b0;
            data_r  <= '0;
            last_r  <= 1'b0;
            busy_r  <= 1'b0;
            done_r  <= 1'b0;
        end else begin
            case (state_r)
                IDLE: begin
                    if (start) begin
                        state_r <= SEND;
                        snap_r  <= mat_in;
                        idx_r   <= 4'd0;
                        valid_r <= 1'b1;
                        data_r  <= elem_at(mat_in, 4'd0);
                        last_r  <= (LAST_IDX == 4'd0);
                        busy_r  <= 1'b1;
                        done_r  <= 1'b0;
                    end else begin
                        idx_r   <= 4'd0;
                        valid_r <= 1'b0;
                        data_r  <= '0;
                        last_r  <= 1'b0;
                        busy_r  <= 1'b0;
                        done_r  <= 1'b0;
                    end
                end
                SEND: begin
                    if (elem_ready) begin
                        if (idx_r == LAST_IDX) begin
                            state_r <= DONE;
                            idx_r   <= 4'd0;
                            valid_r <= 1'b0;
                            data_r  <= '0;
                            last_r  <= 1'b0;
                            busy_r  <= 1'b0;
                            done_r  <= 1'b1;
                        end else begin
                            idx_r   <= idx_inc_s;
                            data_r  <= next_data_s;
                            last_r  <= (idx_inc_s == LAST_IDX);
                        end
                    end else begin
                        // Backpressure: hold the presented element unchanged.
                        idx_r   <= idx_r;
                        data_r  <= data_r;
                        last_r  <= last_r;
                    end
                end
                DONE: begin
                    // Stay here while start is still high so a level start captures once.
                    if (!start) begin
                        state_r <= IDLE;
                        done_r  <= 1'b0;
                    end else begin
                        done_r  <= 1'b1;
                    end
                end
                default: begin
                    state_r <= IDLE;
                    idx_r   <= 4'd0;
                    valid_r <= 1'b0;
                    data_r  <= '0;
                    last_r  <= 1'b0;
                    busy_r  <= 1'b0;
                    done_r  <= 1'b0;
                end
            endcase
        end
    end

    assign elem_valid = valid_r;
    assign elem_data  = data_r;
    assign elem_idx   = idx_r;
    assign elem_last  = last_r;
    assign busy       = busy_r;
    assign done       = done_r;

endmodule
